// File: rtl/lsu_master_pkg.sv
// rtl/lsu_master_pkg.sv - shared op codes, FSM states and decode helpers for the load/store unit
package lsu_pkg;

   typedef enum logic [2:0] {
      LSU_OP_LW  = 3'd0,
      LSU_OP_LH  = 3'd1,
      LSU_OP_LHU = 3'd2,
      LSU_OP_LB  = 3'd3,
      LSU_OP_LBU = 3'd4,
      LSU_OP_SW  = 3'd5,
      LSU_OP_SH  = 3'd6,
      LSU_OP_SB  = 3'd7
   } lsu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STORE  = 3'd2,
      ST_RMW_RD = 3'd3,
      ST_RMW_WR = 3'd4,
      ST_ERR    = 3'd5
   } lsu_state_e;

   function automatic logic is_load(lsu_op_e op);
      return op inside {LSU_OP_LW, LSU_OP_LH, LSU_OP_LHU, LSU_OP_LB, LSU_OP_LBU};
   endfunction

   function automatic logic is_store(lsu_op_e op);
      return op inside {LSU_OP_SW, LSU_OP_SH, LSU_OP_SB};
   endfunction

   function automatic logic is_misaligned(lsu_op_e op, logic [1:0] byteOff);
      logic bad;
      case (op)
         LSU_OP_LW, LSU_OP_SW:              bad = (byteOff != 2'b00);
         LSU_OP_LH, LSU_OP_LHU, LSU_OP_SH:  bad = byteOff[0];
         default:                           bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_master_if.sv
// rtl/lsu_master_if.sv - request/response and data-memory signals of the load/store unit
interface lsu_master_if;

   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;

   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic        memWE;
   logic [31:0] memAddr;
   logic [31:0] memWD;
   logic [31:0] memPC;
   logic [31:0] memRD;

   modport master (
      input  req_valid, req_op, req_addr, req_wdata, req_pc, memRD,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output memWE, memAddr, memWD, memPC
   );

   modport slave (
      output req_valid, req_op, req_addr, req_wdata, req_pc, memRD,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  memWE, memAddr, memWD, memPC
   );

endinterface

// File: rtl/lsu_master_lane.sv
// rtl/lsu_master_lane.sv - combinational little-endian lane extract/extend and sub-word store merge
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [31:0] ldWord,
   input  logic [31:0] stWord,
   input  logic [31:0] wdata,
   input  logic [1:0]  byteOff,
   input  lsu_op_e     op,
   output logic [31:0] rdata,
   output logic [31:0] merged
);

   logic [7:0]  ldByte;
   logic [15:0] ldHalf;

   always_comb begin
      ldByte = ldWord[7:0];
      case (byteOff)
         2'd0:    ldByte = ldWord[7:0];
         2'd1:    ldByte = ldWord[15:8];
         2'd2:    ldByte = ldWord[23:16];
         default: ldByte = ldWord[31:24];
      endcase
      ldHalf = byteOff[1] ? ldWord[31:16] : ldWord[15:0];

      rdata = ldWord;
      case (op)
         LSU_OP_LB:  rdata = {{24{ldByte[7]}}, ldByte};
         LSU_OP_LBU: rdata = {24'h0, ldByte};
         LSU_OP_LH:  rdata = {{16{ldHalf[15]}}, ldHalf};
         LSU_OP_LHU: rdata = {16'h0, ldHalf};
         default:    rdata = ldWord;
      endcase
   end

   // Only the addressed lane of the previously read word is replaced.
   always_comb begin
      merged = stWord;
      case (op)
         LSU_OP_SW: merged = wdata;
         LSU_OP_SH: begin
            if (byteOff[1]) merged[31:16] = wdata[15:0];
            else            merged[15:0]  = wdata[15:0];
         end
         LSU_OP_SB: begin
            case (byteOff)
               2'd0:    merged[7:0]   = wdata[7:0];
               2'd1:    merged[15:8]  = wdata[7:0];
               2'd2:    merged[23:16] = wdata[7:0];
               default: merged[31:24] = wdata[7:0];
            endcase
         end
         default: merged = stWord;
      endcase
   end

endmodule

// File: rtl/lsu_master.sv
// rtl/lsu_master.sv - single-outstanding load/store unit driving a word-wide data memory port
module lsu_master
   import lsu_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter logic [31:0] ADDR_SIZE = 32'h0000_3000
)(
   input  logic         clk,
   input  logic         reset,
   lsu_master_if.master bus
);

   lsu_state_e  state, stateNext;
   lsu_op_e     opQ;
   logic [31:0] addrQ, wdataQ, pcQ, rmwWord;
   logic        respValid, respErr;
   logic [31:0] respRdata;

   lsu_op_e     reqOp;
   logic        accept, reqErr;
   logic [32:0] reqOffset;
   logic [31:0] ldData, mergedWord;

   assign reqOp  = lsu_op_e'(bus.req_op);
   assign accept = bus.req_valid && (state == ST_IDLE);

   // Borrow out of the subtraction flags addresses below the window.
   assign reqOffset = {1'b0, bus.req_addr} - {1'b0, ADDR_BASE};
   assign reqErr    = is_misaligned(reqOp, bus.req_addr[1:0])
                    || reqOffset[32]
                    || (reqOffset[31:0] >= ADDR_SIZE);

   lsu_lane u_lane (
      .ldWord  (bus.memRD),
      .stWord  (rmwWord),
      .wdata   (wdataQ),
      .byteOff (addrQ[1:0]),
      .op      (opQ),
      .rdata   (ldData),
      .merged  (mergedWord)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (reqErr)                  stateNext = ST_ERR;
               else if (is_load(reqOp))     stateNext = ST_LOAD;
               else if (reqOp == LSU_OP_SW) stateNext = ST_STORE;
               else                         stateNext = ST_RMW_RD;
            end
         end
         ST_RMW_RD: stateNext = ST_RMW_WR;
         ST_LOAD, ST_STORE, ST_RMW_WR, ST_ERR: stateNext = ST_IDLE;
         default: stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opQ     <= LSU_OP_LW;
         addrQ   <= '0;
         wdataQ  <= '0;
         pcQ     <= '0;
         rmwWord <= '0;
      end else begin
         if (accept) begin
            opQ    <= reqOp;
            addrQ  <= bus.req_addr;
            wdataQ <= bus.req_wdata;
            pcQ    <= bus.req_pc;
         end
         if (state == ST_RMW_RD) rmwWord <= bus.memRD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         respValid <= 1'b0;
         respRdata <= '0;
         respErr   <= 1'b0;
      end else begin
         respValid <= 1'b0;
         respRdata <= '0;
         respErr   <= 1'b0;
         case (state)
            ST_LOAD, ST_STORE, ST_RMW_WR: begin
               respValid <= 1'b1;
               respRdata <= is_store(opQ) ? 32'h0 : ldData;
            end
            ST_ERR: begin
               respValid <= 1'b1;
               respErr   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Memory-side outputs depend on the state register only, so an async
   // reset removes a pending write before the next edge.
   assign bus.req_ready  = (state == ST_IDLE);
   assign bus.resp_valid = respValid;
   assign bus.resp_rdata = respRdata;
   assign bus.resp_err   = respErr;
   assign bus.memWE      = (state == ST_STORE) || (state == ST_RMW_WR);
   assign bus.memAddr    = (state inside {ST_LOAD, ST_STORE, ST_RMW_RD, ST_RMW_WR})
                           ? {addrQ[31:2], 2'b00} : 32'h0;
   assign bus.memWD      = (state == ST_STORE)  ? wdataQ
                         : (state == ST_RMW_WR) ? mergedWord : 32'h0;
   assign bus.memPC      = (state != ST_IDLE) ? pcQ : 32'h0;

endmodule

// File: tb/tb_lsu_master.sv
// tb/tb_lsu_master.sv - scoreboard bench for lsu_master with a word-array reference memory
module tb_lsu_master;
   import lsu_pkg::*;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam logic [31:0] SIZE  = 32'h0000_3000;
   localparam int          WORDS = 3072;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   lsu_master_if bus();

   lsu_master #(.ADDR_BASE(BASE), .ADDR_SIZE(SIZE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] mem    [0:WORDS-1];
   logic [31:0] refMem [0:WORDS-1];
   logic [11:0] memIdx;
   logic        memHit;

   assign memIdx    = 12'((bus.memAddr - BASE) >> 2);
   assign memHit    = (bus.memAddr - BASE) < SIZE;
   assign bus.memRD = memHit ? mem[memIdx] : 32'h0;

   always @(posedge clk) if (bus.memWE && memHit) mem[memIdx] <= bus.memWD;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [31:0] rdata; logic err; int cycle; } resp_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; logic [31:0] pc; } wr_t;
   resp_t respQ[$];
   wr_t   wrQ[$];

   int nChecks = 0;
   int nPass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic refErr(input int op, input logic [31:0] a);
      int sz;
      if (op == LSU_OP_LW || op == LSU_OP_SW) sz = 4;
      else if (op == LSU_OP_LH || op == LSU_OP_LHU || op == LSU_OP_SH) sz = 2;
      else sz = 1;
      if ((a % sz) != 0) return 1'b1;
      return (a - BASE) >= SIZE;
   endfunction

   function automatic logic [31:0] refLoad(input int op, input logic [31:0] w, input int off);
      logic [31:0] v;
      v = w >> (8 * off);
      case (op)
         LSU_OP_LB:  begin v = v & 32'hFF;   if (v >= 128)   v = v - 256;   end
         LSU_OP_LBU: v = v & 32'hFF;
         LSU_OP_LH:  begin v = v & 32'hFFFF; if (v >= 32768) v = v - 65536; end
         LSU_OP_LHU: v = v & 32'hFFFF;
         default:    v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] refStore(input int op, input logic [31:0] w,
                                            input logic [31:0] wd, input int off);
      logic [31:0] mask;
      if (op == LSU_OP_SW) return wd;
      mask = (op == LSU_OP_SH) ? 32'hFFFF : 32'hFF;
      return (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
   endfunction

   task automatic issue(input int op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] pc, input bit track, output int acc);
      int n;
      int wi;
      int off;
      resp_t r;
      wr_t w;
      n = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'(op);
      bus.req_addr  = a;
      bus.req_wdata = wd;
      bus.req_pc    = pc;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
      acc = cyc + 1;
      if (track) begin
         off = int'(a[1:0]);
         wi  = int'((a - BASE) >> 2);
         r.rdata = 32'h0;
         r.err   = 1'b0;
         r.cycle = acc + 1;
         if (refErr(op, a)) begin
            r.err = 1'b1;
         end else if (op <= LSU_OP_LBU) begin
            r.rdata = refLoad(op, refMem[wi], off);
         end else begin
            w.addr = {a[31:2], 2'b00};
            w.data = refStore(op, refMem[wi], wd, off);
            w.pc   = pc;
            refMem[wi] = w.data;
            wrQ.push_back(w);
            if (op != LSU_OP_SW) r.cycle = acc + 2;
         end
         respQ.push_back(r);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.req_valid = 1'b0;
      while ((respQ.size() != 0 || wrQ.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
   endtask

   always @(negedge clk) begin : resp_monitor
      resp_t r;
      if (!reset && bus.resp_valid) begin
         if (respQ.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
         else begin
            r = respQ.pop_front();
            chk("resp_rdata", bus.resp_rdata, r.rdata);
            chk("resp_err",   32'(bus.resp_err), 32'(r.err));
            chk("resp_cycle", cyc, r.cycle);
         end
      end
   end

   always @(negedge clk) begin : wr_monitor
      wr_t w;
      if (!reset && bus.memWE) begin
         if (wrQ.size() == 0) chk("unexpected_memWE", 32'd1, 32'd0);
         else begin
            w = wrQ.pop_front();
            chk("memAddr", bus.memAddr, w.addr);
            chk("memWD",   bus.memWD,   w.data);
            chk("memPC",   bus.memPC,   w.pc);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a0, a1;
      int op;
      int sel;
      int bad;
      logic [31:0] addr;

      for (int i = 0; i < WORDS; i++) begin
         mem[i]    = 32'h0;
         refMem[i] = 32'h0;
      end
      mem[8]  = 32'h1122_3344;  refMem[8]  = 32'h1122_3344;
      mem[16] = 32'h5566_7788;  refMem[16] = 32'h5566_7788;

      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      bus.req_pc    = 32'h0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_req_ready",  32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
      chk("rst_resp_err",   32'(bus.resp_err), 32'd0);
      chk("rst_memWE",      32'(bus.memWE), 32'd0);
      chk("rst_memAddr",    bus.memAddr, 32'h0);
      chk("rst_memWD",      bus.memWD, 32'h0);
      chk("rst_memPC",      bus.memPC, 32'h0);

      issue(LSU_OP_SW,  32'h10, 32'hDEAD_BEEF, 32'h100, 1, a0);
      issue(LSU_OP_SW,  32'h10, 32'h8899_AABB, 32'h104, 1, a0);
      issue(LSU_OP_LB,  32'h13, 32'h0, 32'h108, 1, a0);
      issue(LSU_OP_LBU, 32'h13, 32'h0, 32'h10C, 1, a0);
      issue(LSU_OP_LH,  32'h12, 32'h0, 32'h110, 1, a0);
      issue(LSU_OP_LHU, 32'h10, 32'h0, 32'h114, 1, a0);
      issue(LSU_OP_SB,  32'h21, 32'h0000_00EE, 32'h118, 1, a0);
      drain();
      chk("sb_merge_word", mem[8], 32'h1122_EE44);
      issue(LSU_OP_SH,  32'h22, 32'h0000_CAFE, 32'h11C, 1, a0);
      drain();
      chk("sh_merge_word", mem[8], 32'hCAFE_EE44);

      issue(LSU_OP_LW,  32'h06,   32'h0, 32'h120, 1, a0);
      issue(LSU_OP_SH,  32'h05,   32'h1234, 32'h124, 1, a0);
      issue(LSU_OP_LB,  32'h3000, 32'h0, 32'h128, 1, a0);
      issue(LSU_OP_SW,  32'h2FFC, 32'h1234_5678, 32'h12C, 1, a0);
      issue(LSU_OP_LW,  32'h2FFC, 32'h0, 32'h130, 1, a0);
      drain();

      issue(LSU_OP_SW, 32'h0, 32'hA5A5_0F0F, 32'h200, 1, a0);
      issue(LSU_OP_LW, 32'h0, 32'h0, 32'h204, 1, a1);
      chk("b2b_accept_gap", 32'(a1 - a0), 32'd2);
      drain();

      issue(LSU_OP_SB, 32'h41, 32'h0000_00AA, 32'h300, 0, a0);
      @(posedge clk);
      #1;
      chk("rmw_wr_memWE", 32'(bus.memWE), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_memWE",      32'(bus.memWE), 32'd0);
      chk("async_rst_memAddr",    bus.memAddr, 32'h0);
      chk("async_rst_memWD",      bus.memWD, 32'h0);
      chk("async_rst_memPC",      bus.memPC, 32'h0);
      chk("async_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_target_word", mem[16], 32'h5566_7788);

      for (int i = 0; i < 300; i++) begin
         op  = int'($urandom_range(0, 7));
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      addr = 32'h3000 + $urandom_range(0, 255);
         else if (sel == 1) addr = $urandom;
         else               addr = $urandom_range(0, 63) * 4 + $urandom_range(0, 3);
         issue(op, addr, $urandom, $urandom, 1, a0);
         if ($urandom_range(0, 3) == 0) begin
            bus.req_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
         end
      end
      drain();

      chk("resp_queue_empty", 32'(respQ.size()), 32'd0);
      chk("wr_queue_empty",   32'(wrQ.size()), 32'd0);
      bad = 0;
      for (int i = 0; i < WORDS; i++) if (mem[i] !== refMem[i]) bad++;
      chk("mem_image_bad_words", 32'(bad), 32'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Initiator-side load/store unit that drives the word-wide data-memory port: memWE, memAddr, memWD, memPC out; memRD in.
- memRD is combinational from memAddr, and a write commits on the rising clk edge when memWE=1.
- Accepts one request at a time from the execute stage and performs:
  - byte and halfword sign/zero extension on loads;
  - read-modify-write for sub-word stores;
  - alignment and range checking.
- Returns a one-cycle response pulse to the pipeline stall/writeback logic.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of the first data-memory word.
- ADDR_SIZE, 32'h0000_3000, size of the data-memory window in bytes (3072 words).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_op  in  3  operation code (LSU_OP_*).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned for SH/SB.
- req_pc  in  32  PC of the instruction, forwarded to memPC.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range access.
- memWE  out  1  memory write enable.
- memAddr  out  32  word-aligned byte address (bits[1:0]=0).
- memWD  out  32  memory write data.
- memPC  out  32  PC for the memory write trace.
- memRD  in  32  memory read data, combinational from memAddr.

Behaviour:
- Single clock clk. reset is asynchronous and active-high: all state registers clear immediately on reset assertion, independent of clk.
- Reset values:
  - state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
  - memWE=0, memAddr=0, memWD=0, memPC=0.
  - req_ready=1 once reset is released.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, ERR.
- req_ready = (state==IDLE). A request is accepted on an edge where req_valid && req_ready; op/addr/wdata/pc are latched at that edge.
- Error check at accept time: error if either condition holds.
  - Misaligned: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
  - Out of range: addr<ADDR_BASE, or addr>=ADDR_BASE+ADDR_SIZE.
- Transitions out of IDLE on accept:
  - error -> ERR;
  - loads -> LOAD;
  - SW -> STORE;
  - SH/SB -> RMW_RD.
- LOAD (1 cycle): memAddr={addr[31:2],2'b00}. At the end edge, select the lane from memRD, extend it, register it to resp_rdata, pulse resp_valid, go to IDLE.
  - Lanes are little-endian: byte k = memRD[8k+7:8k]; half h = memRD[16h+15:16h].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- STORE (1 cycle): memWE=1, memWD=wdata. At the end edge the memory writes, resp_valid pulses, go to IDLE.
- RMW_RD (1 cycle): capture memRD into an internal word register.
- RMW_WR (1 cycle): memWE=1, memWD = captured word with the addressed lane replaced by wdata[7:0] or wdata[15:0]. resp_valid pulses at the end edge.
- ERR (1 cycle): memWE=0. resp_valid=1, resp_err=1, resp_rdata=0 at the end edge.
- Latency from accept edge N to the edge that raises resp_valid:
  - N+1 for loads, SW and errors;
  - N+2 for SH/SB.
- resp_valid is high for exactly one cycle. There is no response back-pressure.
- req_ready is high again in the same cycle as resp_valid, so back-to-back requests lose no cycle.
- memWE is decoded from the state register only, never from req_* inputs. Reset asserted mid-RMW therefore drops memWE immediately and no partial write occurs.
- memPC = latched pc while busy, 0 in IDLE. memAddr and memWD are 0 when not used.
- req_valid while busy is ignored; the requester holds it until req_ready.

Decomposition:
- Shared package lsu_pkg:
  - LSU_OP_LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7;
  - the state encoding;
  - helper functions is_load/is_store.
- Sub-module lsu_lane: purely combinational.
  - Load extract/extend: (word, addr[1:0], op) -> rdata.
  - Store merge: (word, wdata, addr[1:0], op) -> merged word.

Test Plan:
- SW addr 0x10 wdata 0xDEADBEEF, accept edge N -> memWE=1 for one cycle with memAddr=0x10, memWD=0xDEADBEEF; resp_valid after N+1, resp_err=0.
- With word 0x10 = 0x8899AABB: LB 0x13 -> resp_rdata 0xFFFFFF88; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB.
- Word 0x20 = 0x11223344, SB 0x21 wdata 0x000000EE -> RMW_RD then RMW_WR writes 0x1122EE44; resp_valid after N+2; SH 0x22 wdata 0xCAFE -> 0xCAFEEE44.
- LW 0x06, SH 0x05, LB 0x3000 -> each gives resp_err=1, resp_rdata=0, no memWE pulse, resp_valid after N+1.
- Back-to-back SW 0x0 then LW 0x0 with req_valid held high -> LW accepted in the cycle resp_valid pulses, returns the stored value; no idle gap.
- Assert reset asynchronously during RMW_WR -> memWE falls before the next clk edge, the target word is unchanged, all outputs go to reset values, req_ready=1 after release.
